uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a transmit request, pulses the serializer load and shift strobes, and drives the 2-bit select of the registered TX output mux through start, data, optional parity and 1 or 2 stop bits. Every bit period is exactly one Bit_Tick interval; the baud generator supplies Bit_Tick. The serializer, parity calculator and output mux are separate existing blocks.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..16); bit counter width = clog2(DATA_WIDTH).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
Data_Valid  input  1  transmit request; sampled only in IDLE
PAR_EN  input  1  1 = append parity bit; latched at accept
Stop2  input  1  1 = two stop bits; latched at accept
Bit_Tick  input  1  one-cycle baud strobe; may be held high continuously (1 cycle per bit)
MUX_Sel  output  2  mux select: 00 start, 01 serial data, 10 parity, 11 stop/idle
Ser_En  output  1  serializer shift strobe, one cycle
Load  output  1  serializer/parity capture strobe, one cycle
Busy  output  1  frame in progress
Done  output  1  one-cycle pulse at frame end

Behaviour:
- All outputs registered. Reset (async, RST=0): state IDLE, bit_cnt=0, MUX_Sel=11, Busy=0, Ser_En=0, Load=0, Done=0, cfg regs=0.
- Reset mid-frame aborts immediately. The line returns to idle-high via MUX_Sel=11, and no Done pulse is issued.
- States: IDLE, ARM, START, DATA, PARITY, STOP1, STOP2.
- IDLE: MUX_Sel=11, Busy=0. If Data_Valid=1, go to ARM, pulse Load next cycle, and latch PAR_EN->par_q and Stop2->stop2_q. A Bit_Tick in the accept cycle is not consumed.
- ARM: Busy=1, MUX_Sel=11. On Bit_Tick, go to START. This aligns the start bit to a full tick period.
- START: MUX_Sel=00. On Bit_Tick, go to DATA with bit_cnt=0.
- DATA: MUX_Sel=01.
  - Each Bit_Tick pulses Ser_En and increments bit_cnt.
  - On the tick with bit_cnt==DATA_WIDTH-1: go to PARITY if par_q, else STOP1. bit_cnt clears to 0.
  - Ser_En therefore pulses exactly DATA_WIDTH times per frame.
- PARITY: MUX_Sel=10. On Bit_Tick, go to STOP1.
- STOP1: MUX_Sel=11. On Bit_Tick, go to STOP2 if stop2_q. Otherwise go to IDLE and pulse Done.
- STOP2: MUX_Sel=11. On Bit_Tick, go to IDLE and pulse Done.
- Busy=1 in every state except IDLE. It deasserts in the same cycle Done asserts.
- Output timing: MUX_Sel, Ser_En and Done update on the clock edge that samples Bit_Tick=1. The downstream registered mux adds one further cycle, so TX line latency from select is 1 cycle.
- Frame length = 1 + DATA_WIDTH + par_q + 1 + stop2_q tick periods, measured from START entry to IDLE.
- Data_Valid, PAR_EN and Stop2 are ignored while Busy; there is no queuing.
- Back-to-back: Data_Valid high in the first IDLE cycle after Done is accepted, giving a minimum gap of one ARM wait.
- PAR_EN/Stop2 changes during a frame have no effect; only the values latched at accept are used.

Decomposition:
- Shared package uart_tx_pkg:
  - MUX_Sel encodings SEL_START=2'b00, SEL_DATA=2'b01, SEL_PAR=2'b10, SEL_STOP=2'b11.
  - State enum.
  - The mux and serializer import the same constants.
- No sub-module. The bit counter and config latches are inline; a separate counter module is not warranted.

Test Plan:
1. Reset: hold RST=0 while toggling inputs -> MUX_Sel=11, Busy=0, Ser_En=Load=Done=0 throughout. Release -> IDLE, outputs unchanged.
2. W=8, PAR_EN=0, Stop2=0, Bit_Tick every 4 cycles, one Data_Valid pulse:
   - Load pulses once, 1 cycle after accept.
   - MUX_Sel sequence is 00 x1, 01 x8, 11 x1 tick periods.
   - Ser_En fires 8 times, 4 cycles apart.
   - Done fires once, 40 cycles after START entry.
3. PAR_EN=1, Stop2=1, same tick rate -> MUX_Sel shows 10 for one period after data, then 11 for two periods. Frame = 12 periods = 48 cycles; Done at end.
4. Bit_Tick tied high -> each bit lasts 1 cycle; frame completes in 10 cycles after ARM with no skipped states. Data_Valid held high gives back-to-back frames with exactly one IDLE cycle plus one ARM cycle between Done and the next START.
5. Data_Valid and PAR_EN toggled during DATA state -> no new Load pulse and frame format unchanged. Data_Valid and Bit_Tick asserted in the same IDLE cycle -> ARM entered and START waits for the next tick.
6. RST asserted at DATA bit_cnt=3 -> MUX_Sel=11 and Busy=0 asynchronously, with no Done. After release, a new request produces a full clean frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: TX mux select encodings and
// the frame sequencer state encoding.
package uart_tx_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP1  = 3'd5,
    ST_STOP2  = 3'd6
  } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: strobes the serializer and steps the TX mux
// select through start, data, optional parity and one or two stop bits.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle-high, waiting for Data_Valid
// ST_ARM    | request accepted, waiting for a tick to align the start bit
// ST_START  | start bit on the line
// ST_DATA   | data bits, one Ser_En per tick
// ST_PARITY | parity bit (only when par_q)
// ST_STOP1  | first stop bit
// ST_STOP2  | second stop bit (only when stop2_q)
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       Stop2,
  input  logic       Bit_Tick,
  output logic [1:0] MUX_Sel,
  output logic       Ser_En,
  output logic       Load,
  output logic       Busy,
  output logic       Done
);

  // A one-bit counter is kept for DATA_WIDTH=1 so the vector never collapses.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             par_q, stop2_q;
  logic             accept;

  logic [1:0]       sel_nxt;
  logic             ser_nxt, load_nxt, busy_nxt, done_nxt;

  assign accept = (state == ST_IDLE) && Data_Valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      if (accept) begin
        par_q   <= PAR_EN;
        stop2_q <= Stop2;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    unique case (state)
      ST_IDLE: begin
        if (Data_Valid) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (Bit_Tick) state_nxt = ST_START;
      end
      ST_START: begin
        if (Bit_Tick) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        if (Bit_Tick) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = par_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (Bit_Tick) state_nxt = ST_STOP1;
      end
      ST_STOP1: begin
        if (Bit_Tick) state_nxt = stop2_q ? ST_STOP2 : ST_IDLE;
      end
      ST_STOP2: begin
        if (Bit_Tick) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt   = ST_IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered values
  // change on the same edge as the state itself.
  always_comb begin
    sel_nxt  = SEL_STOP;
    ser_nxt  = (state == ST_DATA) && Bit_Tick;
    load_nxt = accept;
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = ((state == ST_STOP1) || (state == ST_STOP2)) && (state_nxt == ST_IDLE);
    case (state_nxt)
      ST_START:  sel_nxt = SEL_START;
      ST_DATA:   sel_nxt = SEL_DATA;
      ST_PARITY: sel_nxt = SEL_PAR;
      default:   sel_nxt = SEL_STOP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MUX_Sel <= SEL_STOP;
      Ser_En  <= 1'b0;
      Load    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      MUX_Sel <= sel_nxt;
      Ser_En  <= ser_nxt;
      Load    <= load_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle vector table with tick
// patterns, plus tick-rate frames, back-to-back and mid-frame reset sequences.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv, par_en, stop2, tick;
  logic [1:0] sel;
  logic       ser, load, busy, done;

  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(clk), .RST(rst_n), .Data_Valid(dv), .PAR_EN(par_en), .Stop2(stop2),
    .Bit_Tick(tick), .MUX_Sel(sel), .Ser_En(ser), .Load(load), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv, par, s2, tick;
    logic [1:0] sel;
    logic       ser, load, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic a_dv, a_par, a_s2, a_tick,
                              input logic [1:0] e_sel,
                              input logic e_ser, e_load, e_busy, e_done);
    vec_t v;
    v.dv = a_dv; v.par = a_par; v.s2 = a_s2; v.tick = a_tick;
    v.sel = e_sel; v.ser = e_ser; v.load = e_load; v.busy = e_busy; v.done = e_done;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({sel, ser, load, busy, done});
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv = 0; par_en = 0; stop2 = 0; tick = 0;
    end
  endtask

  // Tick every 4 cycles; PAR_EN/Stop2 are inverted after accept to prove latching.
  task automatic run_frame(input logic par, input logic s2, input string tag);
    int loads = 0, sers = 0, dones = 0, n_dat = 0, n_par = 0, n_stop = 0;
    int last_ser = -1, start_c = -1, done_c = -1;
    int gap_bad = 0;
    int periods = 10 + int'(par) + int'(s2);
    for (int cyc = 0; cyc < 200 && done_c < 0; cyc++) begin
      @(negedge clk);
      dv     = (cyc == 0);
      par_en = (cyc == 0) ? par : ~par;
      stop2  = (cyc == 0) ? s2 : ~s2;
      tick   = ((cyc % 4) == 3);
      @(posedge clk); #1;
      if (load) loads++;
      if (ser) begin
        if (last_ser >= 0 && cyc - last_ser != 4) gap_bad++;
        last_ser = cyc;
        sers++;
      end
      if (busy && sel == SEL_START && start_c < 0) start_c = cyc;
      if (busy && start_c >= 0) begin
        if (sel == SEL_DATA) n_dat++;
        if (sel == SEL_PAR)  n_par++;
        if (sel == SEL_STOP) n_stop++;
      end
      if (done) begin
        dones++;
        done_c = cyc;
      end
    end
    chk({tag, "_done_seen"}, int'(done_c >= 0), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dv = 0; tick = 1;
      @(posedge clk); #1;
      if (done) dones++;
      if (load) loads++;
    end
    tick = 0;
    chk({tag, "_load_count"}, loads, 1);
    chk({tag, "_ser_count"}, sers, 8);
    chk({tag, "_ser_gap_bad"}, gap_bad, 0);
    chk({tag, "_data_cycles"}, n_dat, 32);
    chk({tag, "_parity_cycles"}, n_par, 4 * int'(par));
    chk({tag, "_stop_cycles"}, n_stop, 4 * (1 + int'(s2)));
    chk({tag, "_frame_cycles"}, done_c - start_c, 4 * periods);
    chk({tag, "_done_count"}, dones, 1);
  endtask

  initial begin
    rst_n = 0; dv = 0; par_en = 0; stop2 = 0; tick = 0;

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dv = i[0]; tick = 1; par_en = i[1]; stop2 = ~i[0];
      @(posedge clk); #1;
      chk($sformatf("reset_hold_%0d", i), outs(), 6'b11_0_0_0_0);
    end
    @(negedge clk);
    dv = 0; tick = 0; par_en = 0; stop2 = 0;
    rst_n = 1;
    @(posedge clk); #1;
    chk("reset_release", outs(), 6'b11_0_0_0_0);

    // Frame A: parity, 1 stop, tick tied high; accept coincides with a tick
    add(1,1,0,1, 2'b11,0,1,1,0);
    add(0,0,0,1, 2'b00,0,0,1,0);
    add(0,0,0,1, 2'b01,0,0,1,0);
    for (int i = 0; i < 7; i++) add(0,0,0,1, 2'b01,1,0,1,0);
    add(0,0,0,1, 2'b10,1,0,1,0);
    add(0,0,0,1, 2'b11,0,0,1,0);
    add(0,0,0,1, 2'b11,0,0,0,1);
    add(0,0,0,0, 2'b11,0,0,0,0);
    // Frame B: no parity, 2 stops, gapped ticks, DV/PAR_EN toggled in DATA
    add(1,0,1,0, 2'b11,0,1,1,0);
    add(0,0,0,0, 2'b11,0,0,1,0);
    add(0,0,0,1, 2'b00,0,0,1,0);
    add(0,0,0,0, 2'b00,0,0,1,0);
    add(0,0,0,1, 2'b01,0,0,1,0);
    for (int i = 0; i < 7; i++) add(logic'(i < 2), logic'(i < 2), 0, 1, 2'b01,1,0,1,0);
    add(0,0,0,1, 2'b11,1,0,1,0);
    add(0,0,0,1, 2'b11,0,0,1,0);
    add(0,0,0,0, 2'b11,0,0,1,0);
    add(0,0,0,1, 2'b11,0,0,0,1);
    add(0,0,0,0, 2'b11,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      dv = vecs[i].dv; par_en = vecs[i].par; stop2 = vecs[i].s2; tick = vecs[i].tick;
      @(posedge clk); #1;
      chk($sformatf("vec_%0d", i), outs(),
          int'({vecs[i].sel, vecs[i].ser, vecs[i].load, vecs[i].busy, vecs[i].done}));
    end
    idle_cycles(3);

    run_frame(1'b0, 1'b0, "frame_8n1");
    idle_cycles(3);
    run_frame(1'b1, 1'b1, "frame_8p2");
    idle_cycles(3);

    // Back-to-back frames with tick and Data_Valid held high
    begin
      int starts[$];
      int dones[$];
      int sers = 0;
      logic [1:0] prev_sel = SEL_STOP;
      for (int cyc = 0; cyc < 24; cyc++) begin
        @(negedge clk);
        dv = 1; tick = 1; par_en = 0; stop2 = 0;
        @(posedge clk); #1;
        if (sel == SEL_START && prev_sel != SEL_START) starts.push_back(cyc);
        if (done) dones.push_back(cyc);
        if (ser) sers++;
        prev_sel = sel;
      end
      @(negedge clk);
      dv = 0; tick = 0;
      chk("b2b_starts", starts.size(), 2);
      chk("b2b_dones", dones.size(), 2);
      chk("b2b_sers", sers, 16);
      if (starts.size() == 2 && dones.size() == 2) begin
        chk("b2b_first_start", starts[0], 1);
        chk("b2b_frame1_len", dones[0] - starts[0], 10);
        chk("b2b_gap", starts[1] - dones[0], 2);
        chk("b2b_frame2_len", dones[1] - starts[1], 10);
      end else begin
        chk("b2b_event_count_ok", 0, 1);
      end
    end
    idle_cycles(4);

    // Reset asserted during DATA with bit_cnt=3
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      dv = (cyc == 0); tick = 1; par_en = 0; stop2 = 0;
      @(posedge clk); #1;
    end
    chk("abort_in_data", outs(), 6'b01_1_0_1_0);
    #2 rst_n = 0;
    #1 chk("abort_async", outs(), 6'b11_0_0_0_0);
    begin
      int dones = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        dv = ~dv;
        @(posedge clk); #1;
        if (done || busy) dones++;
      end
      chk("abort_quiet", dones, 0);
    end
    @(negedge clk);
    dv = 0; tick = 0;
    rst_n = 1;
    idle_cycles(2);
    run_frame(1'b0, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
